// File: rtl/pe_crossbar_ctx.sv
// pe_crossbar_ctx: context-sequenced NUM_IN x NUM_OUT PE crossbar with registered sink outputs.
// Optional build macro PE_XBAR_HOLD_EN: select value 2^SEL_W-1 holds the sink's previous data/valid.
module pe_crossbar_ctx #(
  parameter int unsigned DW        = 32,
  parameter int unsigned NUM_IN    = 9,
  parameter int unsigned NUM_OUT   = 7,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned CTX_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IN*DW-1:0]           din,
  input  logic [NUM_IN-1:0]              din_valid,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [$clog2(CTX_DEPTH)-1:0]   cfg_addr,
  input  logic [NUM_OUT*SEL_W-1:0]       cfg_data,
  input  logic [$clog2(CTX_DEPTH):0]     ctx_len,
  input  logic                           start,
  input  logic                           stop,
  output logic                           busy,
  output logic [$clog2(CTX_DEPTH)-1:0]   ctx_idx,
  output logic [NUM_OUT*DW-1:0]          dout,
  output logic [NUM_OUT-1:0]             dout_valid
);

  localparam int unsigned CW    = $clog2(CTX_DEPTH);
  localparam int unsigned LW    = CW + 1;
  localparam int unsigned CFG_W = NUM_OUT * SEL_W;
`ifdef PE_XBAR_HOLD_EN
  localparam logic [SEL_W-1:0] SEL_HOLD = '1;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [CFG_W-1:0]        ctx_mem [CTX_DEPTH];
  logic [CFG_W-1:0]        cur_cfg;
  logic [LW-1:0]           len_clamp;
  logic [CW-1:0]           last_idx;
  logic [SEL_W-1:0]        sel;
  logic [NUM_OUT*DW-1:0]   xb_data;
  logic [NUM_OUT-1:0]      xb_valid;

  // Effective cycle length: 0 behaves as 1, anything above the depth saturates.
  always_comb begin
    len_clamp = ctx_len;
    if (ctx_len == '0) begin
      len_clamp = LW'(1);
    end else if (ctx_len > LW'(CTX_DEPTH)) begin
      len_clamp = LW'(CTX_DEPTH);
    end
  end

  assign last_idx = CW'(len_clamp - LW'(1));
  assign cur_cfg  = ctx_mem[ctx_idx];

  // Per-sink source mux; unmatched selects give all-ones data with valid low.
  always_comb begin
    xb_data  = '1;
    xb_valid = '0;
    sel      = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      sel = cur_cfg[o*SEL_W +: SEL_W];
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i)) begin
          xb_data[o*DW +: DW] = din[i*DW +: DW];
          xb_valid[o]         = din_valid[i];
        end
      end
`ifdef PE_XBAR_HOLD_EN
      if (sel == SEL_HOLD) begin
        xb_data[o*DW +: DW] = dout[o*DW +: DW];
        xb_valid[o]         = dout_valid[o];
      end
`endif
    end
  end

  // Control FSM, context store and registered crossbar outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
      ctx_idx    <= '0;
      dout       <= '0;
      dout_valid <= '0;
      for (int k = 0; k < CTX_DEPTH; k++) begin
        ctx_mem[k] <= '1;
      end
    end else begin
      case (state)
        IDLE: begin
          dout_valid <= '0;
          ctx_idx    <= '0;
          if (cfg_valid) begin
            ctx_mem[cfg_addr] <= cfg_data;
          end
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
            ctx_idx    <= '0;
            dout_valid <= '0;
          end else begin
            dout       <= xb_data;
            dout_valid <= xb_valid;
            // >= keeps the index in range if ctx_len shrinks mid-run
            ctx_idx    <= (ctx_idx >= last_idx) ? '0 : ctx_idx + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_crossbar_ctx.sv
// Scoreboard bench for pe_crossbar_ctx: directed stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares. Honors PE_XBAR_HOLD_EN when the build defines it.
module tb_pe_crossbar_ctx;

  localparam int unsigned DW = 32;
  localparam int unsigned NI = 9;
  localparam int unsigned NO = 7;
  localparam int unsigned SW = 4;
  localparam int unsigned CD = 4;
  localparam int unsigned CW = 2;

  localparam logic [NO*DW-1:0] ALL1     = '1;
  localparam logic [NO*DW-1:0] ALL0     = '0;
  localparam logic [NO*SW-1:0] CFG_NONE = {NO{4'h9}};
`ifdef PE_XBAR_HOLD_EN
  localparam logic [NO*DW-1:0] DEF_D = ALL0;
`else
  localparam logic [NO*DW-1:0] DEF_D = ALL1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NI*DW-1:0]  din;
  logic [NI-1:0]     din_valid;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CW-1:0]     cfg_addr;
  logic [NO*SW-1:0]  cfg_data;
  logic [CW:0]       ctx_len;
  logic              start;
  logic              stop;
  logic              busy;
  logic [CW-1:0]     ctx_idx;
  logic [NO*DW-1:0]  dout;
  logic [NO-1:0]     dout_valid;

  pe_crossbar_ctx #(
    .DW(DW), .NUM_IN(NI), .NUM_OUT(NO), .SEL_W(SW), .CTX_DEPTH(CD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ctx_len(ctx_len), .start(start), .stop(stop),
    .busy(busy), .ctx_idx(ctx_idx), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    string            name;
    logic [NO*DW-1:0] d;
    logic [NO-1:0]    v;
    logic [CW-1:0]    idx;
    logic             b;
    logic             r;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the expectation stamped for this cycle against the sampled outputs.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      if (sb_q[0].cyc < cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (sb_q[0].cyc == cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        if (dout === e.d && dout_valid === e.v && ctx_idx === e.idx &&
            busy === e.b && cfg_ready === e.r) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got dout=%h valid=%b idx=%0d busy=%b ready=%b want dout=%h valid=%b idx=%0d busy=%b ready=%b",
                   e.name, dout, dout_valid, ctx_idx, busy, cfg_ready, e.d, e.v, e.idx, e.b, e.r);
        end
      end
    end
  end

  function automatic logic [DW-1:0] src_val(int i);
    case (i)
      2:       return 32'hA5A5_A5A5;
      8:       return 32'h1234_5678;
      default: return 32'hC0DE_0000 + 32'(i);
    endcase
  endfunction

  function automatic logic [NO*DW-1:0] dset(logic [NO*DW-1:0] base, int sink, logic [DW-1:0] val);
    logic [NO*DW-1:0] r;
    r = base;
    r[sink*DW +: DW] = val;
    return r;
  endfunction

  function automatic logic [NO*SW-1:0] cset(logic [NO*SW-1:0] base, int sink, logic [SW-1:0] sel);
    logic [NO*SW-1:0] r;
    r = base;
    r[sink*SW +: SW] = sel;
    return r;
  endfunction

  // Expectation for the outputs right after the next rising edge, then advance one cycle.
  task automatic cycle_exp(input string name, input logic [NO*DW-1:0] d, input logic [NO-1:0] v,
                           input logic [CW-1:0] idx, input logic b, input logic r);
    exp_t e;
    e.cyc = cyc + 1; e.name = name; e.d = d; e.v = v; e.idx = idx; e.b = b; e.r = r;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [NO*DW-1:0] e0, e1, e2, ea, eb8, ef;
  logic [NO-1:0]    vf;

  initial begin
    for (int i = 0; i < NI; i++) din[i*DW +: DW] = src_val(i);
    din_valid = 9'h1DF;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    ctx_len = 3'd1; start = 1'b0; stop = 1'b0;

    e0  = dset(ALL1, 1, src_val(0));
    e1  = dset(ALL1, 2, src_val(5));
    e2  = dset(dset(ALL1, 3, src_val(7)), 6, src_val(7));
    ea  = dset(ALL1, 0, src_val(2));
    eb8 = dset(ALL1, 0, src_val(8));

    repeat (2) @(posedge clk);
    #1;
    cycle_exp("reset_held", ALL0, 7'b0, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cycle_exp("reset_release", ALL0, 7'b0, 2'd0, 1'b0, 1'b1);

    // Default contexts
    start = 1'b1;
    cycle_exp("a_entry", ALL0, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    cycle_exp("a_default_ctx", DEF_D, 7'b0, 2'd0, 1'b1, 1'b0);
    stop = 1'b1;
    cycle_exp("a_stop", DEF_D, 7'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b0;

    // Write together with start; first RUN cycle must see the new context
    cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = cset(CFG_NONE, 0, 4'd8); start = 1'b1;
    cycle_exp("b_entry", DEF_D, 7'b0, 2'd0, 1'b1, 1'b0);
    cfg_valid = 1'b0; start = 1'b0;
    cycle_exp("b_sel8", eb8, 7'b0000001, 2'd0, 1'b1, 1'b0);
    cycle_exp("b_len1_idx", eb8, 7'b0000001, 2'd0, 1'b1, 1'b0);
    stop = 1'b1;
    cycle_exp("b_stop", eb8, 7'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b0;

    // Three contexts cycled, including an invalid source and a broadcast
    cfg_valid = 1'b1;
    cfg_addr = 2'd0; cfg_data = cset(CFG_NONE, 1, 4'd0);
    cycle_exp("c_wr0", eb8, 7'b0, 2'd0, 1'b0, 1'b1);
    cfg_addr = 2'd1; cfg_data = cset(CFG_NONE, 2, 4'd5);
    cycle_exp("c_wr1", eb8, 7'b0, 2'd0, 1'b0, 1'b1);
    cfg_addr = 2'd2; cfg_data = cset(cset(CFG_NONE, 3, 4'd7), 6, 4'd7);
    cycle_exp("c_wr2", eb8, 7'b0, 2'd0, 1'b0, 1'b1);
    cfg_valid = 1'b0; ctx_len = 3'd3; start = 1'b1;
    cycle_exp("c_entry", eb8, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      case (k % 3)
        0:       cycle_exp("c_run_ctx0", e0, 7'b0000010, CW'((k + 1) % 3), 1'b1, 1'b0);
        1:       cycle_exp("c_run_ctx1", e1, 7'b0000000, CW'((k + 1) % 3), 1'b1, 1'b0);
        default: cycle_exp("c_run_ctx2", e2, 7'b1001000, CW'((k + 1) % 3), 1'b1, 1'b0);
      endcase
    end
    stop = 1'b1;
    cycle_exp("c_stop", e0, 7'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b0;

    // Writes refused while running, accepted once back in IDLE
    ctx_len = 3'd1; start = 1'b1;
    cycle_exp("d_entry", e0, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = cset(CFG_NONE, 0, 4'd2);
    cycle_exp("d_run_wr0", e0, 7'b0000010, 2'd0, 1'b1, 1'b0);
    cycle_exp("d_run_wr1", e0, 7'b0000010, 2'd0, 1'b1, 1'b0);
    stop = 1'b1;
    cycle_exp("d_stop", e0, 7'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b0;
    cycle_exp("d_idle_wr", e0, 7'b0, 2'd0, 1'b0, 1'b1);
    cfg_valid = 1'b0; start = 1'b1;
    cycle_exp("d_entry2", e0, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    cycle_exp("d_new_ctx", ea, 7'b0000001, 2'd0, 1'b1, 1'b0);
    stop = 1'b1;
    cycle_exp("d_stop2", ea, 7'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b0;

    // ctx_len 0 behaves as 1
    ctx_len = 3'd0; start = 1'b1;
    cycle_exp("e0_entry", ea, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    cycle_exp("e0_len0_a", ea, 7'b0000001, 2'd0, 1'b1, 1'b0);
    cycle_exp("e0_len0_b", ea, 7'b0000001, 2'd0, 1'b1, 1'b0);
    stop = 1'b1;
    cycle_exp("e0_stop", ea, 7'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b0;

    // ctx_len 7 saturates to the full depth of 4
    cfg_valid = 1'b1; cfg_addr = 2'd3; cfg_data = CFG_NONE;
    cycle_exp("e7_wr3", ea, 7'b0, 2'd0, 1'b0, 1'b1);
    cfg_valid = 1'b0; ctx_len = 3'd7; start = 1'b1;
    cycle_exp("e7_entry", ea, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    cycle_exp("e7_ctx0", ea,   7'b0000001, 2'd1, 1'b1, 1'b0);
    cycle_exp("e7_ctx1", e1,   7'b0000000, 2'd2, 1'b1, 1'b0);
    cycle_exp("e7_ctx2", e2,   7'b1001000, 2'd3, 1'b1, 1'b0);
    cycle_exp("e7_ctx3", ALL1, 7'b0000000, 2'd0, 1'b1, 1'b0);
    cycle_exp("e7_wrap", ea,   7'b0000001, 2'd1, 1'b1, 1'b0);
    stop = 1'b1;
    cycle_exp("e7_stop", ea, 7'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b0;

    // All-ones select right after a valid source
`ifdef PE_XBAR_HOLD_EN
    ef = ea;   vf = 7'b0000001;
`else
    ef = ALL1; vf = 7'b0000000;
`endif
    cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = cset(CFG_NONE, 0, 4'd15);
    cycle_exp("f_wr", ea, 7'b0, 2'd0, 1'b0, 1'b1);
    cfg_valid = 1'b0; ctx_len = 3'd2; start = 1'b1;
    cycle_exp("f_entry", ea, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    cycle_exp("f_sel2", ea, 7'b0000001, 2'd1, 1'b1, 1'b0);
    cycle_exp("f_sel15", ef, vf, 2'd0, 1'b1, 1'b0);
    cycle_exp("f_sel2_again", ea, 7'b0000001, 2'd1, 1'b1, 1'b0);
    stop = 1'b1;
    cycle_exp("f_stop", ea, 7'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b0;

    // Reset while running restores reset values and clears the context store
    ctx_len = 3'd1; start = 1'b1;
    cycle_exp("g_entry", ea, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    cycle_exp("g_run", ea, 7'b0000001, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    cycle_exp("g_rst_mid_run", ALL0, 7'b0, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cycle_exp("g_release", ALL0, 7'b0, 2'd0, 1'b0, 1'b1);
    start = 1'b1;
    cycle_exp("g_entry2", ALL0, 7'b0, 2'd0, 1'b1, 1'b0);
    start = 1'b0;
    cycle_exp("g_ctx_cleared", DEF_D, 7'b0, 2'd0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      $display("FAIL %s: expectation left unchecked (cycle %0d)", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_crossbar_ctx.md
PE_CROSSBAR_CTX -- requirements
Module: pe_crossbar_ctx

Interface
REQ-001 Parameter DW, default 32, data width of every input and output channel.
REQ-002 Parameter NUM_IN, default 9, number of crossbar sources (N,S,W,E,R0-R3,FU).
REQ-003 Parameter NUM_OUT, default 7, number of crossbar sinks (LSU,A,B,N,S,W,E).
REQ-004 Parameter SEL_W, default 4, select field width per sink; SEL_W SHALL satisfy 2^SEL_W > NUM_IN.
REQ-005 Parameter CTX_DEPTH, default 4, number of stored switch contexts; power of two, at least 2; CW = log2(CTX_DEPTH).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 din  in  NUM_IN*DW  flattened sources; source i occupies bits [i*DW +: DW].
REQ-009 din_valid  in  NUM_IN  per-source valid.
REQ-010 cfg_valid  in  1  context write request.
REQ-011 cfg_ready  out  1  context write accepted when high.
REQ-012 cfg_addr  in  CW  context slot to write.
REQ-013 cfg_data  in  NUM_OUT*SEL_W  switch word; sink o select at [o*SEL_W +: SEL_W].
REQ-014 ctx_len  in  CW+1  number of contexts cycled in RUN.
REQ-015 start  in  1  one-cycle pulse, IDLE->RUN.
REQ-016 stop  in  1  one-cycle pulse, RUN->IDLE.
REQ-017 busy  out  1  high in RUN.
REQ-018 ctx_idx  out  CW  context applied in the current cycle.
REQ-019 dout  out  NUM_OUT*DW  registered sink data, sink o at [o*DW +: DW].
REQ-020 dout_valid  out  NUM_OUT  registered per-sink valid.

Function
REQ-021 FSM states IDLE and RUN only; IDLE->RUN on start; RUN->IDLE on stop; stop in IDLE and start in RUN are ignored.
REQ-022 cfg_ready SHALL equal (state==IDLE); a write occurs on cfg_valid && cfg_ready; writes are never accepted in RUN.
REQ-023 Context write and start in the same cycle: both take effect; the first RUN cycle SHALL use the newly written contents.
REQ-024 In RUN, ctx_idx advances by 1 each cycle and wraps to 0 after reaching L-1, where L = ctx_len clamped to [1, CTX_DEPTH] (0 treated as 1).
REQ-025 On entering RUN, ctx_idx SHALL be 0; on RUN->IDLE, ctx_idx returns to 0.
REQ-026 In RUN, for each sink o with select s = ctx[ctx_idx][o]: if s < NUM_IN, dout[o] <= din[s] and dout_valid[o] <= din_valid[s] at the next edge (latency 1 cycle).
REQ-027 In RUN, s >= NUM_IN SHALL drive dout[o] <= all-ones and dout_valid[o] <= 0 (except REQ-033).
REQ-028 In IDLE, dout holds its last value and dout_valid is 0 from the first IDLE cycle.
REQ-029 Multiple sinks selecting one source SHALL all receive it (broadcast); no arbitration.
REQ-030 Sinks are independent; selects never interact.

Reset
REQ-031 On rst_n low: state IDLE, ctx_idx 0, dout all-zero, dout_valid 0, busy 0, every context slot all-ones (all sinks unconnected); reset mid-RUN aborts immediately with these values.

Configuration
REQ-032 Macro PE_XBAR_HOLD_EN absent: behaviour per REQ-027 for every out-of-range select.
REQ-033 Macro PE_XBAR_HOLD_EN defined: select value 2^SEL_W-1 SHALL hold dout[o] and dout_valid[o] at their previous values; other out-of-range values follow REQ-027.

Verification
REQ-034 Reset, then start with default contexts -> all dout 32'hFFFFFFFF, dout_valid 0, busy 1.
REQ-035 Write ctx0 sink0 sel=8, din[8]=0x12345678 valid, ctx_len=1, start -> one cycle later dout[0]=0x12345678, dout_valid[0]=1, ctx_idx stays 0.
REQ-036 Write ctx0..2 distinct selects, ctx_len=3, start, run 7 cycles -> ctx_idx 0,1,2,0,1,2,0; dout follows matching context one cycle late.
REQ-037 cfg_valid in RUN -> cfg_ready 0, context unchanged; after stop, same write accepted.
REQ-038 ctx_len=0 and ctx_len=7 with CTX_DEPTH=4 -> cycle lengths 1 and 4 respectively.
REQ-039 With PE_XBAR_HOLD_EN, sel=15 after sel=2 (din[2]=0xA5A5A5A5) -> dout holds 0xA5A5A5A5, valid held; without macro -> 0xFFFFFFFF, valid 0.
